// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port arbitrated add/sub unit.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_arbiter_arith_unit.sv
// Combinational add/sub with signed overflow; ALU_ARBITER_SAT_EN clamps
// overflowing results to the signed limits instead of wrapping.
module arith_unit
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH-1:0] raw;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;

  always_comb begin
    raw    = (sub == OP_ADD) ? a + b : a - b;
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    sign_r = raw[WIDTH-1];
    if (sub == OP_SUB) ovf = (sign_a != sign_b) && (sign_r != sign_a);
    else               ovf = (sign_a == sign_b) && (sign_r != sign_a);
`ifdef ALU_ARBITER_SAT_EN
    // On overflow the true result always carries the sign of A.
    if (ovf) result = sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else     result = raw;
`else
    result = raw;
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single add/sub unit.
// Optional saturation is selected with macro ALU_ARBITER_SAT_EN (see arith_unit).
//   state | meaning
//   IDLE  | arbitrate, accept one request
//   EXEC  | compute and register result/overflow
//   RESP  | hold response until consumer accepts
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0]            req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_ovf
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             grant_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  arith_unit #(.WIDTH(WIDTH)) u_arith (
    .a      (a_q),
    .b      (b_q),
    .sub    (sub_q),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_id  = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    id_d         = id_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    case (state_q)
      IDLE: begin
        if ((req_valid & req_ready) != 2'b00) begin
          a_d          = req_a[grant_id];
          b_d          = req_b[grant_id];
          sub_d        = req_sub[grant_id];
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        ovf_d    = alu_ovf;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      id_q         <= 1'b0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      id_q         <= id_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (WIDTH=8); honours ALU_ARBITER_SAT_EN.
module tb_alu_arbiter;

  typedef struct {
    bit         id;
    logic [7:0] res;
    bit         ovf;
  } exp_t;

`ifdef ALU_ARBITER_SAT_EN
  localparam logic [7:0] EXP_ADD_OVF = 8'h7F;
  localparam logic [7:0] EXP_SUB_OVF = 8'h80;
`else
  localparam logic [7:0] EXP_ADD_OVF = 8'h80;
  localparam logic [7:0] EXP_SUB_OVF = 8'h7F;
`endif

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][7:0] req_a;
  logic [1:0][7:0] req_b;
  logic [1:0]      req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [7:0]      rsp_result;
  logic            rsp_ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   rand_bp = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input bit id, input logic [7:0] a, input logic [7:0] b, input bit sub);
    exp_t        m;
    int          sa;
    int          sb;
    int          t;
    logic [31:0] tv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sub ? sa - sb : sa + sb;
    tv = t;
    m.id  = id;
    m.ovf = (t > 127) || (t < -128);
    m.res = tv[7:0];
`ifdef ALU_ARBITER_SAT_EN
    if (m.ovf) m.res = (t > 0) ? 8'h7F : 8'h80;
`endif
    return m;
  endfunction

  // Response monitor: a handshake completes on the posedge after this negedge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d result=%02h ovf=%0d, required no response", rsp_id, rsp_result, rsp_ovf);
      end else begin
        mon_e = sb_q.pop_front();
        if (rsp_id !== mon_e.id || rsp_result !== mon_e.res || rsp_ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL rsp_compare: got id=%0d result=%02h ovf=%0d, required id=%0d result=%02h ovf=%0d",
                   rsp_id, rsp_result, rsp_ovf, mon_e.id, mon_e.res, mon_e.ovf);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Presents one request and returns #1 after the transfer edge (DUT in EXEC).
  task automatic issue(input bit port, input logic [7:0] a, input logic [7:0] b, input bit sub, input bit expect_rsp);
    bit done;
    done = 0;
    req_a[port]     = a;
    req_b[port]     = b;
    req_sub[port]   = sub;
    req_valid[port] = 1'b1;
    if (expect_rsp) sb_q.push_back(model(port, a, b, sub));
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready[port]) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    req_valid[port] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: port=%0d got req_ready=%b, required grant within 60 cycles", port, req_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #7;
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got req_ready=%b rsp_valid=%b, required 00 0", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_id !== 1'b0 || rsp_result !== 8'h00 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got id=%0d result=%02h ovf=%0d, required 0 00 0", rsp_id, rsp_result, rsp_ovf);
    end
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_ovf();
    rsp_ready = 1'b0;
    issue(1'b0, 8'h50, 8'h30, 1'b0, 1'b1);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: got rsp_valid=%b one cycle after accept, required 0", rsp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== EXP_ADD_OVF || rsp_ovf !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: got valid=%b result=%02h ovf=%0d id=%0d, required 1 %02h 1 0",
               rsp_valid, rsp_result, rsp_ovf, rsp_id, EXP_ADD_OVF);
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_sub();
    rsp_ready = 1'b0;
    issue(1'b1, 8'h80, 8'h01, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== EXP_SUB_OVF || rsp_ovf !== 1'b1 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: got valid=%b result=%02h ovf=%0d id=%0d, required 1 %02h 1 1",
               rsp_valid, rsp_result, rsp_ovf, rsp_id, EXP_SUB_OVF);
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_round_robin();
    bit exp_port;
    int n;
    exp_port   = 1'b0;
    n          = 0;
    rst_n      = 1'b0;
    rsp_ready  = 1'b1;
    req_a[0]   = 8'h10; req_b[0] = 8'h20; req_sub[0] = 1'b0;
    req_a[1]   = 8'h03; req_b[1] = 8'h09; req_sub[1] = 1'b1;
    req_valid  = 2'b11;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready !== (exp_port ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant%0d: got req_ready=%b, required %b", n, req_ready, exp_port ? 2'b10 : 2'b01);
        end
        sb_q.push_back(model(exp_port, req_a[exp_port], req_b[exp_port], req_sub[exp_port]));
        exp_port = ~exp_port;
        n++;
      end
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d grants, required 4", n);
    end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
    @(posedge clk);
    #1 req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'hFE || rsp_ovf !== 1'b0 || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b result=%02h ovf=%0d id=%0d req_ready=%b, required 1 fe 0 1 00",
                 i, rsp_valid, rsp_result, rsp_ovf, rsp_id, req_ready);
      end
    end
    @(posedge clk);
    #1;
    req_a[0] = 8'h22; req_b[0] = 8'h11; req_sub[0] = 1'b0;
    sb_q.push_back(model(1'b0, 8'h22, 8'h11, 1'b0));
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got rsp_valid=%b req_ready=%b, required 0 01", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    drain();
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b1;
    issue(1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
    req_valid = 2'b10;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || rsp_id !== 1'b0 || rsp_result !== 8'h00 || rsp_ovf !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got valid=%b req_ready=%b id=%0d result=%02h ovf=%0d, required 0 00 0 00 0",
               rsp_valid, req_ready, rsp_id, rsp_result, rsp_ovf);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_no_rsp%0d: got rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    @(posedge clk);
    #1 rand_bp = 1'b1;
    for (int i = 0; i < 255; i++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_sub   = 2'b00;
    rsp_ready = 1'b0;
    test_reset();
    test_add_ovf();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
